// File: rtl/signal_analyser.sv
// Purpose: registers the sampled bus each cycle, timestamps it and flags changed samples.
// Latency: one cycle from data_in to data_out/data_time/new_data.
// Backpressure: none; new_data is a one-cycle pulse the consumer must capture.
module signal_analyser #(
    parameter int DATA_WIDTH = 8,
    parameter int TIME_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [TIME_WIDTH-1:0] data_time,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  new_data
);

    // Free-running cycle index since reset release; wraps modulo 2^TIME_WIDTH.
    logic [TIME_WIDTH-1:0] cnt;
    // Forces the first sample after reset to be reported even if it equals
    // the cleared data_out value.
    logic                  first;
    // Sample differs from the one currently held on data_out.
    logic                  changed;

    // Change detect against the previous registered sample.
    always_comb begin
        changed = first || (data_in != data_out);
    end

    // Sample register, timestamp counter and change flag; reset dominates
    // any data activity on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            data_time <= '0;
            data_out  <= '0;
            new_data  <= 1'b0;
            first     <= 1'b1;
        end else begin
            data_out  <= data_in;
            data_time <= cnt;
            cnt       <= cnt + TIME_WIDTH'(1);
            new_data  <= changed;
            first     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_signal_analyser.sv
// Bench for signal_analyser: directed vectors on a default-width instance and
// on a 4-bit-timestamp instance that exercises counter wrap.
module tb_signal_analyser;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic [31:0] data_time;
    logic [7:0]  data_out;
    logic        new_data;

    logic        rst4;
    logic [7:0]  data_in4;
    logic [3:0]  data_time4;
    logic [7:0]  data_out4;
    logic        new_data4;

    int errors = 0;
    int checks = 0;

    signal_analyser #(.DATA_WIDTH(8), .TIME_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_time (data_time),
        .data_out  (data_out),
        .new_data  (new_data)
    );

    signal_analyser #(.DATA_WIDTH(8), .TIME_WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst4),
        .data_in   (data_in4),
        .data_time (data_time4),
        .data_out  (data_out4),
        .new_data  (new_data4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        data_in  = 8'd0;
        rst4     = 1'b0;
        data_in4 = 8'h3C;
        step();
        step();
        chk("reset_time", data_time, 0);
        chk("reset_out",  data_out, 0);
        chk("reset_new",  {31'd0, new_data}, 0);

        // Release with 69 held, then change to 100.
        rst     = 1'b1;
        data_in = 8'd69;
        step();
        chk("s1_time", data_time, 0);
        chk("s1_out",  data_out, 69);
        chk("s1_new",  {31'd0, new_data}, 1);
        step();
        chk("s2_time", data_time, 1);
        chk("s2_out",  data_out, 69);
        chk("s2_new",  {31'd0, new_data}, 0);
        step();
        chk("s3_time", data_time, 2);
        chk("s3_new",  {31'd0, new_data}, 0);
        data_in = 8'd100;
        step();
        chk("s4_time", data_time, 3);
        chk("s4_out",  data_out, 100);
        chk("s4_new",  {31'd0, new_data}, 1);
        step();
        chk("s5_time", data_time, 4);
        chk("s5_new",  {31'd0, new_data}, 0);

        // Reset, release with data 0: first sample still flagged.
        rst     = 1'b0;
        data_in = 8'd0;
        step();
        chk("z_rst_time", data_time, 0);
        chk("z_rst_out",  data_out, 0);
        chk("z_rst_new",  {31'd0, new_data}, 0);
        rst = 1'b1;
        step();
        chk("z0_time", data_time, 0);
        chk("z0_out",  data_out, 0);
        chk("z0_new",  {31'd0, new_data}, 1);
        step();
        chk("z1_time", data_time, 1);
        chk("z1_new",  {31'd0, new_data}, 0);
        step();
        chk("z2_time", data_time, 2);
        chk("z2_new",  {31'd0, new_data}, 0);

        // Toggle 0x55/0xAA every cycle.
        for (int i = 0; i < 8; i++) begin
            data_in = (i % 2 == 0) ? 8'h55 : 8'hAA;
            step();
            chk("tog_new",  {31'd0, new_data}, 1);
            chk("tog_time", data_time, 32'(3 + i));
            chk("tog_out",  data_out, (i % 2 == 0) ? 32'h55 : 32'hAA);
        end

        // Hold 0xAA until data_time reaches 50, then reset mid-run.
        for (int i = 0; i < 40; i++) step();
        chk("mid_time", data_time, 50);
        chk("mid_new",  {31'd0, new_data}, 0);
        rst = 1'b0;
        step();
        chk("mid_rst_time", data_time, 0);
        chk("mid_rst_out",  data_out, 0);
        chk("mid_rst_new",  {31'd0, new_data}, 0);
        rst = 1'b1;
        step();
        chk("mid_rel_time", data_time, 0);
        chk("mid_rel_out",  data_out, 32'hAA);
        chk("mid_rel_new",  {31'd0, new_data}, 1);
        step();
        chk("mid_rel2_time", data_time, 1);
        chk("mid_rel2_new",  {31'd0, new_data}, 0);

        // Reset dominates a data change on the reset edge.
        rst     = 1'b0;
        data_in = 8'h11;
        step();
        chk("dom_out", data_out, 0);
        chk("dom_new", {31'd0, new_data}, 0);
        rst = 1'b1;

        // 4-bit timestamp wrap with constant data.
        chk("w_rst_time", {28'd0, data_time4}, 0);
        rst4 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("wrap_time", {28'd0, data_time4}, 32'(k % 16));
            chk("wrap_new",  {31'd0, new_data4}, (k == 0) ? 32'd1 : 32'd0);
        end
        chk("wrap_out", {24'd0, data_out4}, 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signal_analyser.md
# signal_analyser

Front-end sampler for the logic-analyser capture path. It registers an input data bus every clock and keeps a free-running cycle timestamp. It flags the cycles on which the sampled value differs from the previous sample, so downstream capture logic can store only (time, value) change events.

## Interface
Parameters:
- DATA_WIDTH, default 8: width of sampled data bus.
- TIME_WIDTH, default 32: width of timestamp counter.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (asserted when 0). One clock; reset is synchronous and active-low.
- data_in  input  DATA_WIDTH  raw signal sampled every rising edge.
- data_time  output  TIME_WIDTH  timestamp (cycle index since reset release) of the sample currently on data_out.
- data_out  output  DATA_WIDTH  registered copy of data_in.
- new_data  output  1  high for one cycle when data_out holds a changed value.

## Operation
- Internal counter `cnt` (TIME_WIDTH bits) and a `first` flag.
- On a rising edge with rst=0:
  - cnt, data_time, data_out and new_data all clear to 0.
  - first sets to 1.
- On each rising edge with rst=1:
  - data_out <= data_in.
  - data_time <= cnt.
  - cnt <= cnt + 1.
  - new_data <= 1 if first=1 or data_in != data_out (the previous sample); else 0.
  - first <= 0.
- The first sample after reset is always flagged new, even if it equals 0.
- data_time advances every cycle regardless of data activity; it is not held between changes.
- cnt wraps modulo 2^TIME_WIDTH: after all-ones comes 0. Wrap has no effect on new_data.
- No back-pressure: new_data is a single-cycle pulse. Consumers must capture data_out/data_time in that cycle.
- Unsigned arithmetic only; no saturation.

## Timing
- Reset values: data_time=0, data_out=0, new_data=0.
- Latency: data_in sampled at edge k (k=0 is the first edge with rst=1) appears on data_out after edge k, with data_time=k.
- new_data rises in the same cycle the changed value appears on data_out. It falls after the next edge unless data_in changed again.
- Data changing every cycle gives new_data high continuously, with data_time incrementing by 1 each cycle.
- Reset asserted mid-operation: at the next edge, all outputs return to reset values and the timestamp restarts. The next sample after release is flagged new with data_time=0.
- Reset dominates: a data change during the reset edge is ignored.

## Test plan
- Reset, then release with data_in=69. After 1st edge: data_time=0, data_out=69, new_data=1. After 2nd edge: data_time=1, data_out=69, new_data=0. After 3rd edge: data_time=2.
- Continuing the first scenario, set data_in=100 before the 4th edge. After it: data_time=3, data_out=100, new_data=1. After the 5th edge: new_data=0, data_time=4.
- Release reset with data_in=0. Require new_data=1 at data_time=0, then 0 while data_in stays 0.
- Toggle data_in 0x55/0xAA every cycle for 8 cycles. Require new_data high every cycle and data_time incrementing by 1.
- Assert rst=0 for one edge mid-run (data_time≈50), then release with unchanged data. Require outputs 0 during reset, then data_time=0 and new_data=1 after release.
- Use TIME_WIDTH=4 and run 20 cycles. Require data_time to wrap 15→0 with no spurious new_data.
